// File: rtl/rr_arb8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arb8_pkg : shared types, constants and round-robin pick helper   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rr_arb8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Rotate so bit 0 is requester (last+1), then take the lowest set bit.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [IDX_W-1:0] last);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    pick_t              p;
    dbl     = {req, req} >> ({1'b0, last} + 4'd1);
    rot     = dbl[N_REQ-1:0];
    p.found = |rot;
    p.idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) p.idx = last + 3'd1 + 3'(k);
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb8_dec3to8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dec3to8 : combinational 3-to-8 one-hot decoder with enable          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dec3to8
  import rr_arb8_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_onehot
);

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_dec
      assign o_onehot[i] = i_en && (i_idx == IDX_W'(i));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/rr_arb8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arb8 : 8-way round-robin arbiter, registered one-hot grant       |
// | Optional hold-limit preemption: define RR_ARB8_HOLD_LIMIT_EN        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_arb8
  import rr_arb8_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  generate
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
      $error("rr_arb8: HOLD_MAX must be in 1..255");
    end
  endgenerate

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;
  logic [N_REQ-1:0] r_gnt;
  logic             r_vld;

  state_t           w_nxt_state;
  logic [IDX_W-1:0] w_nxt_idx;
  logic [N_REQ-1:0] w_nxt_gnt;
  logic             w_new;
  logic             w_own_req;
  logic             w_preempt;
  pick_t            w_pick;

  assign w_own_req = req[r_idx];
  assign w_pick    = rr_pick(req, r_ptr);

`ifdef RR_ARB8_HOLD_LIMIT_EN
  localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] r_hold;
  logic       w_others;
  assign w_others  = |(req & ~r_gnt);
  assign w_preempt = (r_hold == c_HOLD_LAST) && w_others;
`else
  assign w_preempt = 1'b0;
`endif

  // Owner bit is low or masked out by order when re-picking, so a pick never re-selects it.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_new       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick.found) w_new = 1'b1;
      end
      ST_GRANT: begin
        if (!w_own_req || w_preempt) begin
          if (w_pick.found) w_new = 1'b1;
          else              w_nxt_state = ST_IDLE;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
    if (w_new) begin
      w_nxt_state = ST_GRANT;
      w_nxt_idx   = w_pick.idx;
    end
  end

  dec3to8 u_dec (
    .i_idx    (w_nxt_idx),
    .i_en     (w_nxt_state == ST_GRANT),
    .o_onehot (w_nxt_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 3'd7;
      r_idx   <= '0;
      r_gnt   <= '0;
      r_vld   <= 1'b0;
`ifdef RR_ARB8_HOLD_LIMIT_EN
      r_hold  <= '0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_gnt   <= w_nxt_gnt;
      r_vld   <= (w_nxt_state == ST_GRANT);
      if (w_new) r_ptr <= w_pick.idx;
`ifdef RR_ARB8_HOLD_LIMIT_EN
      if (w_new)                                             r_hold <= '0;
      else if (r_state == ST_GRANT && r_hold != c_HOLD_LAST) r_hold <= r_hold + 8'd1;
`endif
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rr_arb8 : table vectors, corner sequences and random vs model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_rr_arb8;

  localparam int c_HOLD_MAX = 4;
`ifdef RR_ARB8_HOLD_LIMIT_EN
  localparam bit c_HOLD_EN = 1'b1;
`else
  localparam bit c_HOLD_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner (-1 = none), last winner, cycles held.
  int         m_owner;
  int         m_last;
  int         m_held;
  logic [7:0] r_edge;

  rr_arb8 #(.HOLD_MAX(c_HOLD_MAX)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 7;
    m_held  = 0;
  endfunction

  function automatic int find_next(input logic [7:0] r);
    for (int k = 1; k <= 8; k++) begin
      if (r[(m_last + k) % 8]) return (m_last + k) % 8;
    end
    return -1;
  endfunction

  function automatic void model_edge(input logic [7:0] r);
    int  nxt;
    bit  others;
    bit  repick;
    repick = 1'b0;
    if (m_owner < 0) begin
      repick = (r != 8'h00);
    end else begin
      others = 1'b0;
      for (int i = 0; i < 8; i++) if (i != m_owner && r[i]) others = 1'b1;
      if (!r[m_owner]) begin
        if (others) repick = 1'b1;
        else        m_owner = -1;
      end else if (c_HOLD_EN && m_held >= c_HOLD_MAX - 1 && others) begin
        repick = 1'b1;
      end else if (m_held < c_HOLD_MAX - 1) begin
        m_held++;
      end
    end
    if (repick) begin
      nxt     = find_next(r);
      m_owner = nxt;
      m_last  = nxt;
      m_held  = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [7:0] e_gnt, input logic e_vld,
                     input logic [2:0] e_idx, input bit cmp_idx);
    n_checks++;
    if (gnt !== e_gnt || gnt_vld !== e_vld || (cmp_idx && gnt_idx !== e_idx)) begin
      n_fail++;
      $display("FAIL %s t=%0t: gnt=%h vld=%b idx=%0d, expected gnt=%h vld=%b idx=%0d",
               name, $time, gnt, gnt_vld, gnt_idx, e_gnt, e_vld, e_idx);
    end
  endtask

  task automatic chk_model(input string name);
    if (m_owner >= 0) chk(name, 8'd1 << m_owner, 1'b1, 3'(m_owner), 1'b1);
    else              chk(name, 8'h00, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic chk_props(input string name);
    logic [7:0] dec;
    dec = gnt_vld ? (8'd1 << gnt_idx) : 8'h00;
    n_checks++;
    if ($countones(gnt) > 1 || gnt !== dec || (gnt_vld && !r_edge[gnt_idx])) begin
      n_fail++;
      $display("FAIL %s t=%0t: gnt=%h idx=%0d vld=%b req_at_edge=%h",
               name, $time, gnt, gnt_idx, gnt_vld, r_edge);
    end
  endtask

  task automatic step(input logic [7:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    r_edge = r;
    model_edge(r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic       vld;
    logic [2:0] idx;
  } vec_t;

  vec_t tbl [19];

  initial begin
    logic [7:0] r;
    logic [7:0] e;
    r_edge = 8'h00;
    model_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    #12;
    chk("reset_state", 8'h00, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0]  = '{8'h01, 8'h01, 1'b1, 3'd0};
    tbl[1]  = '{8'hFE, 8'h02, 1'b1, 3'd1};
    tbl[2]  = '{8'hFD, 8'h04, 1'b1, 3'd2};
    tbl[3]  = '{8'hFB, 8'h08, 1'b1, 3'd3};
    tbl[4]  = '{8'hF7, 8'h10, 1'b1, 3'd4};
    tbl[5]  = '{8'hEF, 8'h20, 1'b1, 3'd5};
    tbl[6]  = '{8'hDF, 8'h40, 1'b1, 3'd6};
    tbl[7]  = '{8'hBF, 8'h80, 1'b1, 3'd7};
    tbl[8]  = '{8'h7F, 8'h01, 1'b1, 3'd0};
    tbl[9]  = '{8'h20, 8'h20, 1'b1, 3'd5};
    tbl[10] = '{8'h21, 8'h20, 1'b1, 3'd5};
    tbl[11] = '{8'h01, 8'h01, 1'b1, 3'd0};
    tbl[12] = '{8'h00, 8'h00, 1'b0, 3'd0};
    tbl[13] = '{8'h00, 8'h00, 1'b0, 3'd0};
    tbl[14] = '{8'h02, 8'h02, 1'b1, 3'd1};
    tbl[15] = '{8'h0A, 8'h02, 1'b1, 3'd1};
    tbl[16] = '{8'h08, 8'h08, 1'b1, 3'd3};
    tbl[17] = '{8'h0A, 8'h08, 1'b1, 3'd3};
    tbl[18] = '{8'h02, 8'h02, 1'b1, 3'd1};
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].req);
      chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].vld, tbl[i].idx, tbl[i].vld);
    end

    // Two contenders held: alternate every HOLD_MAX cycles only when preemption is built.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(8'h06);
      e = (c_HOLD_EN && ((c / c_HOLD_MAX) % 2 == 1)) ? 8'h04 : 8'h02;
      chk($sformatf("hold_pair%0d", c), e, 1'b1, (e == 8'h04) ? 3'd2 : 3'd1, 1'b1);
    end
    for (int c = 0; c < 20; c++) begin
      step(8'h02);
      chk($sformatf("hold_alone%0d", c), 8'h02, 1'b1, 3'd1, 1'b1);
    end

    // Asynchronous reset mid-grant, then fresh arbitration from IDLE.
    do_reset();
    step(8'h08);
    chk("pre_rst_gnt", 8'h08, 1'b1, 3'd3, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 8'h00, 1'b0, 3'd0, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h08);
    chk("post_rst_gnt", 8'h08, 1'b1, 3'd3, 1'b1);

    do_reset();
    r = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 3))
          0:       r = 8'($urandom);
          1:       r = 8'($urandom) & 8'($urandom);
          2:       r = 8'h01 << $urandom_range(0, 7);
          default: r = 8'h00;
        endcase
      end
      step(r);
      chk_model("rand");
      chk_props("rand_props");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 15, maximum consecutive grant cycles before preemption (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  8  request vector, bit i = requester i.
REQ-005 SHALL have port gnt  output  8  one-hot grant, registered.
REQ-006 SHALL have port gnt_idx  output  3  binary index of granted requester, registered.
REQ-007 SHALL have port gnt_vld  output  1  high when gnt holds a valid grant.

Function
REQ-008 SHALL implement an 8-way round-robin arbiter with a 2-state FSM: IDLE (no grant), GRANT (one requester owns the resource).
REQ-009 SHALL keep a 3-bit last-winner pointer; search order starts at (last+1) mod 8, wraps 7->0, and the first set req bit wins.
REQ-010 IDLE: if req != 0 at an edge -> GRANT with the winner registered; latency 1 cycle from req to gnt.
REQ-011 IDLE: if req == 0 -> stay IDLE, gnt = 0, gnt_vld = 0.
REQ-012 GRANT: if req[gnt_idx] stays high and no preemption applies -> hold grant unchanged.
REQ-013 GRANT: if req[gnt_idx] low at an edge and another req bit high -> grant next winner the same edge (back-to-back, no idle cycle).
REQ-014 GRANT: if req[gnt_idx] low and all other req low -> IDLE next cycle, gnt = 0.
REQ-015 Simultaneous release and new request by the same owner (req[gnt_idx] low then high on later edge) SHALL be treated as a new request subject to round-robin order.
REQ-016 pointer SHALL update to the winner index on every new grant only; held grants do not move it.
REQ-017 gnt SHALL always equal the 3-to-8 decode of gnt_idx when gnt_vld = 1, and 8'h00 otherwise; never more than one bit set.
REQ-018 Requests from non-owners SHALL never alter the current grant except via REQ-021.

Reset
REQ-019 On rst_n low, immediately and asynchronously: state = IDLE, gnt = 8'h00, gnt_idx = 3'd0, gnt_vld = 0, pointer = 3'd7 (so requester 0 has first priority), hold counter = 0.
REQ-020 Reset asserted mid-grant SHALL drop the grant at once; first edge after rst_n release evaluates as IDLE.

Configuration
REQ-021 Macro RR_ARB8_HOLD_LIMIT_EN defined: 8-bit hold counter counts cycles in GRANT (reset to 0 on each new grant); when count reaches HOLD_MAX-1 and any other req bit is high, SHALL preempt to the next round-robin winner at that edge; if no other requester, counter saturates and grant holds.
REQ-022 Macro RR_ARB8_HOLD_LIMIT_EN undefined: no counter is built; grant holds indefinitely while owner req stays high.

Structure
REQ-023 Shared package SHALL hold the FSM state typedef (IDLE, GRANT), the constant N_REQ = 8, and the index width constant IDX_W = 3.
REQ-024 One sub-module SHALL be instantiated: dec3to8, combinational 3-to-8 one-hot decoder producing gnt from the next-index value before the output register.
REQ-025 Round-robin search SHALL be a combinational rotate-priority-encode function; no further sub-modules.

Verification
REQ-026 Reset, req = 8'h01 -> gnt = 8'h01, gnt_idx = 0, gnt_vld = 1 one cycle later.
REQ-027 req = 8'hFF held constantly, owners releasing after one cycle each -> grants 0,1,2,...,7,0 back-to-back with no idle cycle.
REQ-028 Owner 5 granted, pointer 5, req = 8'h21 then bit 5 drops -> next gnt = 8'h01 (wrap 5->0).
REQ-029 With RR_ARB8_HOLD_LIMIT_EN, HOLD_MAX = 4, req = 8'h06 held -> owner 1 for 4 cycles, then owner 2 for 4 cycles, alternating; alone (req = 8'h02) -> owner 1 holds indefinitely.
REQ-030 rst_n pulsed low mid-grant of requester 3 -> gnt = 0 asynchronously; after release with req = 8'h08 -> gnt = 8'h08 one cycle later.
REQ-031 Random req for 10k cycles -> assert gnt one-hot-or-zero, gnt == decode(gnt_idx), no grant to a requester whose req was low at the granting edge.
